pfiform_join_arb: RTL and testbench

Round-robin arbiter that shares the single join port of the PFIFORM packing FIFO between `NREQ` requesters. Each requester presents packets as beats of up to 32 six-bit elements, with a per-beat amount and a last-beat flag. The block grants the join port to one requester for a whole packet, so beats from different packets never interleave. It also reports the total element count of each completed packet. It sits directly upstream of PFIFORM and drives its `JoinEnable`/`JoinAmout`/`JoinData` inputs.

---
 rtl/pfiform_join_arb.sv | 209 ++++++++++++++++++++
 tb/tb_pfiform_join_arb.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfiform_join_arb.sv
// ---------------------------------------------------------------------------
// pfiform_join_arb
//
// Round-robin arbiter in front of the single join port of the PFIFORM packing
// FIFO. One requester owns the join port for a whole packet, so beats from
// different packets never interleave. The element total of each finished
// packet is reported alongside a one-cycle completion pulse.
//
// Parameters
//   NREQ : number of requesters (2..8)
//   DW   : beat data width (32 lanes x 6 bits)
//   AW   : amount width, amount is coded as element count minus 1
//   CW   : width of the saturating packet element counter
//
// Ports
//   i_core_clk  in   clock, everything on the rising edge
//   i_rx_rst    in   asynchronous active-high reset
//   req_valid   in   [NREQ]      requester k has a beat present
//   req_last    in   [NREQ]      requester k beat is the last of its packet
//   req_amount  in   [NREQ*AW]   requester k amount at [k*AW +: AW]
//   req_data    in   [NREQ*DW]   requester k data at [k*DW +: DW]
//   req_ready   out  [NREQ]      requester k beat accepted this cycle
//   JoinEnable  out              beat valid toward PFIFORM
//   JoinAmout   out  [AW]        amount toward PFIFORM (count-1)
//   JoinData    out  [DW]        data toward PFIFORM
//   JoinPermit  in               PFIFORM can take a beat this cycle
//   grant_id    out  [3]         current or most recent granted requester
//   busy        out              high while a packet transfer is in progress
//   pkt_done    out              one-cycle pulse after a last beat is taken
//   pkt_elems   out  [CW]        element total of the packet just completed
// ---------------------------------------------------------------------------
module pfiform_join_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 192,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*AW-1:0]   req_amount,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 JoinEnable,
  output logic [AW-1:0]        JoinAmout,
  output logic [DW-1:0]        JoinData,
  input  logic                 JoinPermit,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [CW-1:0]        pkt_elems
);

  localparam int SW = ((CW > AW + 1) ? CW : AW + 1) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [2:0]      last_grant;
  logic [2:0]      rr_pick;
  logic            rr_found;
  logic            sel_valid;
  logic            sel_last;
  logic [AW-1:0]   sel_amount;
  logic [DW-1:0]   sel_data;
  logic            accept;
  logic            accept_last;
  logic [CW-1:0]   elem_acc;
  logic [CW-1:0]   elem_sum;
  logic [SW-1:0]   sum_wide;

  // Round-robin search. The first pass looks at requesters numbered above
  // the previous winner, the second pass wraps around to the rest, so the
  // previous winner itself has the lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && req_valid[k] && (3'(k) > last_grant)) begin
        rr_found = 1'b1;
        rr_pick  = 3'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && req_valid[k] && (3'(k) <= last_grant)) begin
        rr_found = 1'b1;
        rr_pick  = 3'(k);
      end
    end
  end

  // Select the granted requester's beat. Requester 0 is the fallback, so an
  // out-of-range grant index still yields a defined value instead of X.
  always_comb begin
    sel_valid  = req_valid[0];
    sel_last   = req_last[0];
    sel_amount = req_amount[AW-1:0];
    sel_data   = req_data[DW-1:0];
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == 3'(k)) begin
        sel_valid  = req_valid[k];
        sel_last   = req_last[k];
        sel_amount = req_amount[k*AW +: AW];
        sel_data   = req_data[k*DW +: DW];
      end
    end
  end

  // State register. busy is loaded from the next state so that it is a
  // clean flop output equal to "currently in XFER".
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == XFER);
    end
  end

  // Next-state logic. The grant is held in XFER until the last beat of the
  // packet is actually taken, even if the owner drops valid for a while.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rr_found) begin
          next_state = XFER;
        end
      end
      XFER: begin
        if (accept_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic. In XFER the owner's valid passes straight through and only
  // the owner sees PFIFORM's permit as its ready; nothing is buffered here.
  always_comb begin
    JoinEnable = 1'b0;
    req_ready  = '0;
    if (state == XFER) begin
      JoinEnable = sel_valid;
      for (int k = 0; k < NREQ; k++) begin
        if (grant_id == 3'(k)) begin
          req_ready[k] = JoinPermit;
        end
      end
    end
  end

  assign JoinAmout   = sel_amount;
  assign JoinData    = sel_data;
  assign accept      = JoinEnable & JoinPermit;
  assign accept_last = accept & sel_last;

  // Saturating element adder. The sum is formed one bit wider than either
  // operand so an overflow can be detected and clamped to all ones.
  always_comb begin
    sum_wide = SW'(elem_acc) + SW'(sel_amount) + SW'(1);
    if (sum_wide > SW'({CW{1'b1}})) begin
      elem_sum = '1;
    end else begin
      elem_sum = sum_wide[CW-1:0];
    end
  end

  // Grant register. A new winner is captured only on the IDLE cycle; it
  // then stays visible on grant_id after the packet completes.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      grant_id <= 3'd0;
    end else if ((state == IDLE) && rr_found) begin
      grant_id <= rr_pick;
    end
  end

  // Packet accounting. Starting last_grant at the top requester makes
  // requester 0 the first winner after reset. A reset in mid-packet simply
  // clears everything, so the dropped packet never produces pkt_done.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      last_grant <= 3'(NREQ - 1);
      elem_acc   <= '0;
      pkt_elems  <= '0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= accept_last;
      if (accept) begin
        if (sel_last) begin
          pkt_elems  <= elem_sum;
          elem_acc   <= '0;
          last_grant <= grant_id;
        end else begin
          elem_acc <= elem_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pfiform_join_arb.sv
// ---------------------------------------------------------------------------
// tb_pfiform_join_arb
//
// Directed bench for pfiform_join_arb. Two instances share every input: one
// with the default 16-bit element counter and one with an 8-bit counter so
// saturation can be observed. A transaction-level model of the arbiter is
// checked against both instances every cycle, and a set of hand-computed
// values pins the model down.
// ---------------------------------------------------------------------------
module tb_pfiform_join_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 192;
  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int CW8   = 8;
  localparam int DEPTH = 64;

  logic                tb_sclk = 1'b0;
  logic                i_rx_rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*AW-1:0]  req_amount;
  logic [NREQ*DW-1:0]  req_data;
  logic                JoinPermit;

  logic [NREQ-1:0]     req_ready;
  logic                JoinEnable;
  logic [AW-1:0]       JoinAmout;
  logic [DW-1:0]       JoinData;
  logic [2:0]          grant_id;
  logic                busy;
  logic                pkt_done;
  logic [CW-1:0]       pkt_elems;

  logic [NREQ-1:0]     s_req_ready;
  logic                s_join_enable;
  logic [AW-1:0]       s_join_amout;
  logic [DW-1:0]       s_join_data;
  logic [2:0]          s_grant_id;
  logic                s_busy;
  logic                s_pkt_done;
  logic [CW8-1:0]      s_pkt_elems;

  always #5 tb_sclk = ~tb_sclk;

  pfiform_join_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .CW(CW)) u_dut (
    .i_core_clk (tb_sclk),
    .i_rx_rst   (i_rx_rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_amount (req_amount),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .JoinEnable (JoinEnable),
    .JoinAmout  (JoinAmout),
    .JoinData   (JoinData),
    .JoinPermit (JoinPermit),
    .grant_id   (grant_id),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_elems  (pkt_elems)
  );

  pfiform_join_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .CW(CW8)) u_dut8 (
    .i_core_clk (tb_sclk),
    .i_rx_rst   (i_rx_rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_amount (req_amount),
    .req_data   (req_data),
    .req_ready  (s_req_ready),
    .JoinEnable (s_join_enable),
    .JoinAmout  (s_join_amout),
    .JoinData   (s_join_data),
    .JoinPermit (JoinPermit),
    .grant_id   (s_grant_id),
    .busy       (s_busy),
    .pkt_done   (s_pkt_done),
    .pkt_elems  (s_pkt_elems)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [AW-1:0]   q_amt  [NREQ][DEPTH];
  logic            q_last [NREQ][DEPTH];
  logic [DW-1:0]   q_data [NREQ][DEPTH];
  int              q_head [NREQ];
  int              q_tail [NREQ];
  logic [NREQ-1:0] src_en;

  int accept_cnt = 0;
  int done_cnt   = 0;
  int grant_log [256];
  int done_log  [64];
  bit cmp_on = 1'b0;

  logic       m_busy;
  int         m_grant;
  int         m_last;
  int         m_total;
  logic       m_done;
  int         m_elems16;
  int         m_elems8;
  int         t_cand;
  int         t_pick;
  bit         t_found;
  int         t_sum;

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] make_data(input int k, input int n);
    return {8{8'(k), 8'(n), 8'h5A}};
  endfunction

  task automatic enqueue(input int k, input int amt, input bit last,
                         input logic [DW-1:0] data);
    q_amt[k][q_tail[k]]  = AW'(amt);
    q_last[k][q_tail[k]] = last;
    q_data[k][q_tail[k]] = data;
    q_tail[k]++;
  endtask

  // Present each enabled requester's head-of-queue beat on the inputs.
  task automatic apply_stimulus();
    for (int k = 0; k < NREQ; k++) begin
      if (src_en[k] && (q_head[k] != q_tail[k])) begin
        req_valid[k]             = 1'b1;
        req_last[k]              = q_last[k][q_head[k]];
        req_amount[k*AW +: AW]   = q_amt[k][q_head[k]];
        req_data[k*DW +: DW]     = q_data[k][q_head[k]];
      end else begin
        req_valid[k]             = 1'b0;
        req_last[k]              = 1'b0;
        req_amount[k*AW +: AW]   = '0;
        req_data[k*DW +: DW]     = '0;
      end
    end
  endtask

  // One clock: note which beats are being taken, let the edge pass, then
  // pop those beats and present the next ones.
  task automatic step();
    logic [NREQ-1:0] took;
    @(negedge tb_sclk);
    took = req_valid & req_ready;
    @(posedge tb_sclk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (took[k]) q_head[k]++;
    end
    apply_stimulus();
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((accept_cnt < target) && (n < budget)) begin
      step();
      n++;
    end
    check_output({name, "_accepts"}, DW'(accept_cnt), DW'(target));
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while ((pkt_done !== 1'b1) && (n < budget)) begin
      step();
      n++;
    end
    check_output({name, "_done"}, DW'(pkt_done), DW'(1));
  endtask

  task automatic do_reset();
    i_rx_rst = 1'b1;
    step();
    step();
    i_rx_rst = 1'b0;
  endtask

  // Transaction-level model: whoever is chosen round-robin owns the port
  // until a last beat is taken; packet total is the plain sum of counts,
  // clamped to the counter's maximum.
  always @(posedge tb_sclk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      m_busy    <= 1'b0;
      m_grant   <= 0;
      m_last    <= NREQ - 1;
      m_total   <= 0;
      m_done    <= 1'b0;
      m_elems16 <= 0;
      m_elems8  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        t_found = 1'b0;
        t_pick  = 0;
        for (int off = 1; off <= NREQ; off++) begin
          t_cand = (m_last + off) % NREQ;
          if (!t_found && req_valid[t_cand]) begin
            t_found = 1'b1;
            t_pick  = t_cand;
          end
        end
        if (t_found) begin
          m_busy  <= 1'b1;
          m_grant <= t_pick;
        end
      end else if (req_valid[m_grant] && JoinPermit) begin
        t_sum = m_total + int'(req_amount[m_grant*AW +: AW]) + 1;
        if (req_last[m_grant]) begin
          m_elems16 <= (t_sum > 65535) ? 65535 : t_sum;
          m_elems8  <= (t_sum > 255) ? 255 : t_sum;
          m_done    <= 1'b1;
          m_last    <= m_grant;
          m_total   <= 0;
          m_busy    <= 1'b0;
        end else begin
          m_total <= t_sum;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge tb_sclk) begin
    logic            exp_en;
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]   exp_amt;
    logic [DW-1:0]   exp_data;
    if (cmp_on) begin
      exp_en    = 1'b0;
      exp_ready = '0;
      exp_amt   = '0;
      exp_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (m_busy && (k == m_grant)) begin
          exp_en       = req_valid[k];
          exp_ready[k] = JoinPermit;
          exp_amt      = req_amount[k*AW +: AW];
          exp_data     = req_data[k*DW +: DW];
        end
      end
      check_output("busy", DW'(busy), DW'(m_busy));
      check_output("grant_id", DW'(grant_id), DW'(m_grant));
      check_output("join_enable", DW'(JoinEnable), DW'(exp_en));
      check_output("req_ready", DW'(req_ready), DW'(exp_ready));
      check_output("pkt_done", DW'(pkt_done), DW'(m_done));
      check_output("pkt_elems", DW'(pkt_elems), DW'(m_elems16));
      check_output("pkt_done_cw8", DW'(s_pkt_done), DW'(m_done));
      check_output("pkt_elems_cw8", DW'(s_pkt_elems), DW'(m_elems8));
      check_output("join_enable_cw8", DW'(s_join_enable), DW'(exp_en));
      if (exp_en) begin
        check_output("join_amout", DW'(JoinAmout), DW'(exp_amt));
        check_output("join_data", JoinData, exp_data);
      end
    end
  end

  // Log which requester each accepted beat came from and each packet total.
  always @(negedge tb_sclk) begin
    if (JoinEnable && JoinPermit) begin
      grant_log[accept_cnt % 256] = int'(grant_id);
      accept_cnt++;
    end
    if (pkt_done) begin
      done_log[done_cnt % 64] = int'(pkt_elems);
      done_cnt++;
    end
  end

  initial begin
    int base;
    int dbase;
    i_rx_rst   = 1'b1;
    JoinPermit = 1'b1;
    src_en     = '0;
    req_valid  = '0;
    req_last   = '0;
    req_amount = '0;
    req_data   = '0;
    for (int k = 0; k < NREQ; k++) begin
      q_head[k] = 0;
      q_tail[k] = 0;
    end
    apply_stimulus();
    repeat (2) @(posedge tb_sclk);
    #1;
    cmp_on = 1'b1;

    @(negedge tb_sclk);
    check_output("rst_busy", DW'(busy), DW'(0));
    check_output("rst_grant", DW'(grant_id), DW'(0));
    check_output("rst_enable", DW'(JoinEnable), DW'(0));
    check_output("rst_ready", DW'(req_ready), DW'(0));
    check_output("rst_elems", DW'(pkt_elems), DW'(0));
    @(posedge tb_sclk);
    #1;
    i_rx_rst = 1'b0;

    $display("[TB] single requester, three beats");
    src_en = '1;
    enqueue(0, 9, 1'b0, make_data(0, 0));
    enqueue(0, 18, 1'b0, make_data(0, 0));
    enqueue(0, 31, 1'b1, make_data(0, 0));
    apply_stimulus();
    base = accept_cnt;
    wait_done(20, "t1");
    check_output("t1_elems", DW'(pkt_elems), DW'(61));
    check_output("t1_elems_cw8", DW'(s_pkt_elems), DW'(61));
    check_output("t1_beats", DW'(accept_cnt - base), DW'(3));
    step();
    check_output("t1_single_pulse", DW'(pkt_done), DW'(0));

    $display("[TB] four requesters, round robin");
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NREQ; k++) begin
        enqueue(k, 3 * k + p + 1, 1'b1, make_data(k, p));
      end
    end
    apply_stimulus();
    base = accept_cnt;
    wait_accepts(base + 8, 60, "t2");
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("t2_order%0d", i), DW'(grant_log[(base + i) % 256]), DW'(i % 4));
    end
    step();
    step();

    $display("[TB] owner drops valid mid-packet");
    src_en = 4'b0100;
    enqueue(2, 7, 1'b0, make_data(2, 10));
    enqueue(2, 8, 1'b0, make_data(2, 11));
    enqueue(2, 9, 1'b1, make_data(2, 12));
    enqueue(1, 5, 1'b1, make_data(1, 10));
    apply_stimulus();
    base  = accept_cnt;
    dbase = done_cnt;
    step();
    step();
    src_en = 4'b0010;
    apply_stimulus();
    repeat (5) step();
    check_output("t3_grant_held", DW'(grant_id), DW'(2));
    check_output("t3_gap_beats", DW'(accept_cnt - base), DW'(1));
    src_en = 4'b0110;
    apply_stimulus();
    wait_accepts(base + 4, 20, "t3");
    step();
    check_output("t3_order0", DW'(grant_log[base % 256]), DW'(2));
    check_output("t3_order2", DW'(grant_log[(base + 2) % 256]), DW'(2));
    check_output("t3_order3", DW'(grant_log[(base + 3) % 256]), DW'(1));
    check_output("t3_elems_r2", DW'(done_log[dbase % 64]), DW'(27));
    check_output("t3_elems_r1", DW'(done_log[(dbase + 1) % 64]), DW'(6));

    $display("[TB] permit stalls");
    step();
    src_en = 4'b1000;
    enqueue(3, 4, 1'b0, make_data(3, 20));
    enqueue(3, 6, 1'b1, make_data(3, 21));
    JoinPermit = 1'b1;
    apply_stimulus();
    step();
    base = accept_cnt;
    step();
    JoinPermit = 1'b0;
    #1;
    check_output("t4_ready_stall", DW'(req_ready), DW'(0));
    check_output("t4_enable_stall", DW'(JoinEnable), DW'(1));
    step();
    step();
    JoinPermit = 1'b1;
    #1;
    check_output("t4_ready_go", DW'(req_ready), DW'(4'b1000));
    step();
    check_output("t4_done", DW'(pkt_done), DW'(1));
    check_output("t4_elems", DW'(pkt_elems), DW'(12));
    check_output("t4_beats", DW'(accept_cnt - base), DW'(2));

    $display("[TB] reset mid-packet");
    step();
    src_en = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      enqueue(1, 2, (i == 3), make_data(1, 30 + i));
    end
    apply_stimulus();
    step();
    step();
    step();
    dbase = done_cnt;
    #2;
    i_rx_rst = 1'b1;
    #1;
    check_output("t5_rst_enable", DW'(JoinEnable), DW'(0));
    check_output("t5_rst_busy", DW'(busy), DW'(0));
    check_output("t5_rst_grant", DW'(grant_id), DW'(0));
    check_output("t5_rst_ready", DW'(req_ready), DW'(0));
    check_output("t5_rst_elems", DW'(pkt_elems), DW'(0));
    for (int k = 0; k < NREQ; k++) q_head[k] = q_tail[k];
    apply_stimulus();
    step();
    step();
    i_rx_rst = 1'b0;
    check_output("t5_no_done", DW'(done_cnt - dbase), DW'(0));
    src_en = '1;
    enqueue(1, 1, 1'b1, make_data(1, 40));
    enqueue(0, 2, 1'b1, make_data(0, 40));
    apply_stimulus();
    base = accept_cnt;
    wait_accepts(base + 2, 20, "t5");
    check_output("t5_first", DW'(grant_log[base % 256]), DW'(0));
    check_output("t5_second", DW'(grant_log[(base + 1) % 256]), DW'(1));

    $display("[TB] counter saturation");
    step();
    src_en = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      enqueue(2, 31, (i == 9), make_data(2, 50 + i));
    end
    apply_stimulus();
    wait_done(40, "t6");
    check_output("t6_elems", DW'(pkt_elems), DW'(320));
    check_output("t6_elems_cw8", DW'(s_pkt_elems), DW'(255));
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
